// File: rtl/mac_row_engine_pkg.sv
// Shared definitions for the word-serial row multiplier (mac_row_engine).
package mac_row_engine_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned LEN_WIDTH_DEF  = 7;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        LAST  = 2'd3
    } state_e;

    // Full-width product of two default-width words
    typedef logic [2*DATA_WIDTH_DEF-1:0] prod_t;

endpackage

// File: rtl/mac_row_engine_mac_word.sv
// Combinational single-word multiply-accumulate: {o_carry, o_sum} = x*y + z + cin.
// The 2W-bit result cannot overflow: (2^W-1)^2 + 2(2^W-1) = 2^2W - 1.
module mac_word
    import mac_row_engine_pkg::*;
#(
    parameter int unsigned W = DATA_WIDTH_DEF
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    input  logic [W-1:0] i_cin,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] w_prod;

    // Widen every operand before the arithmetic so no bits are lost
    always_comb begin
        w_prod  = PW'(i_x) * PW'(i_y) + PW'(i_z) + PW'(i_cin);
        o_sum   = w_prod[W-1:0];
        o_carry = w_prod[PW-1:W];
    end

endmodule

// File: rtl/mac_row_engine.sv
// Word-serial row multiplier: R = a * B + Z + c0, B/Z streamed LSW first.
// Emits num_words sum words followed by one carry word (out_last = 1).
// Optional macro MAC_ROW_CIN_EN adds port cin_init as the initial carry c0.
module mac_row_engine
    import mac_row_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [LEN_WIDTH-1:0]  num_words,
`ifdef MAC_ROW_CIN_EN
    input  logic [DATA_WIDTH-1:0] cin_init,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_carry;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] w_c0;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_carry;
    logic [LEN_WIDTH-1:0]  w_count_next;
    logic                  w_out_free;
    logic                  w_in_fire;

`ifdef MAC_ROW_CIN_EN
    assign w_c0 = cin_init;
`else
    assign w_c0 = '0;
`endif

    mac_word #(
        .W (DATA_WIDTH)
    ) u_mac_word (
        .i_x     (r_a),
        .i_y     (b),
        .i_z     (z),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Handshake qualifiers; the output register is free when empty or being popped
    always_comb begin
        w_out_free   = !r_out_valid || out_ready;
        w_in_fire    = (r_state == RUN) && w_out_free && in_valid;
        w_count_next = r_count + 1'b1;
    end

    assign in_ready  = (r_state == RUN) && w_out_free;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign done      = r_done;

    // Control FSM with carry chain and registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_carry     <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_a     <= a;
                            r_len   <= num_words;
                            r_carry <= w_c0;
                            r_count <= '0;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    // A push in the same cycle as a pop reloads the register
                    if (w_in_fire) begin
                        r_out_data  <= w_sum;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_carry     <= w_carry;
                        r_count     <= w_count_next;
                        if (w_count_next == r_len) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (w_out_free) begin
                        r_out_data  <= r_carry;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_state     <= LAST;
                    end
                end
                LAST: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_row_engine.sv
// Directed self-checking bench for mac_row_engine (optional MAC_ROW_CIN_EN case).
module tb_mac_row_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [6:0]  num_words = '0;
`ifdef MAC_ROW_CIN_EN
    logic [31:0] cin_init = '0;
`endif
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] b = '0;
    logic [31:0] z = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [31:0]  tb_b   [0:7];
    logic [31:0]  tb_z   [0:7];
    logic [31:0]  tb_exp [0:8];
    logic [191:0] ref_r;
    logic [127:0] ref_b;
    logic [127:0] ref_z;

    always #5 clk = ~clk;

    mac_row_engine #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .num_words (num_words),
`ifdef MAC_ROW_CIN_EN
        .cin_init  (cin_init),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b         (b),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one row of length n from tb_b/tb_z and checks the stream against tb_exp
    task automatic do_row(input string tag, input int n, input logic [31:0] av, input bit rnd);
        int          in_idx   = 0;
        int          out_idx  = 0;
        int          cyc      = 0;
        int          done_cnt = 0;
        bit          stall    = 1'b0;
        bit          fin      = 1'b0;
        logic [31:0] pd       = '0;
        logic        pl       = 1'b0;
        start     = 1'b1;
        a         = av;
        num_words = n[6:0];
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        while (!fin && cyc < 300) begin
            in_valid  = (in_idx < n);
            b         = (in_idx < n) ? tb_b[in_idx] : 32'hDEAD_BEEF;
            z         = (in_idx < n) ? tb_z[in_idx] : 32'hDEAD_BEEF;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stall) begin
                check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
                check({tag, "_hold_data"}, {32'd0, out_data}, {32'd0, pd});
                check({tag, "_hold_last"}, {63'd0, out_last}, {63'd0, pl});
            end
            if (out_valid && !out_ready)
                check({tag, "_in_ready_held"}, {63'd0, in_ready}, 64'd0);
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                check({tag, "_data"}, {32'd0, out_data}, {32'd0, tb_exp[out_idx]});
                check({tag, "_last"}, {63'd0, out_last}, {63'd0, out_idx == n});
                out_idx++;
                if (out_idx == n + 1) fin = 1'b1;
            end
            if (in_valid && in_ready) in_idx++;
            stall = out_valid && !out_ready;
            pd    = out_data;
            pl    = out_last;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_completed"}, {63'd0, fin}, 64'd1);
        check({tag, "_no_early_done"}, 64'(done_cnt), 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_idle"}, {62'd0, busy, out_valid}, 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_state", {29'd0, in_ready, out_valid, out_last, busy, done, out_data},
              64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // N=1 all ones: p = 0xFFFFFFFF_00000000
        tb_b[0] = 32'hFFFF_FFFF; tb_z[0] = 32'hFFFF_FFFF;
        tb_exp[0] = 32'h0000_0000; tb_exp[1] = 32'hFFFF_FFFF;
        do_row("n1_max", 1, 32'hFFFF_FFFF, 1'b0);

        // N=3 carry propagation
        tb_b[0] = 32'h8000_0000; tb_b[1] = 32'h8000_0000; tb_b[2] = 32'h1;
        tb_z[0] = '0; tb_z[1] = '0; tb_z[2] = '0;
        tb_exp[0] = 32'h0; tb_exp[1] = 32'h1; tb_exp[2] = 32'h3; tb_exp[3] = 32'h0;
        do_row("n3_carry", 3, 32'h2, 1'b0);

        // N=4 random operands with backpressure, reference from wide arithmetic
        begin
            logic [31:0] ra;
            ra = $urandom;
            for (int k = 0; k < 4; k++) begin
                tb_b[k] = $urandom;
                tb_z[k] = $urandom;
            end
            ref_b = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};
            ref_z = {tb_z[3], tb_z[2], tb_z[1], tb_z[0]};
            ref_r = 192'(ra) * 192'(ref_b) + 192'(ref_z);
            for (int k = 0; k < 5; k++) tb_exp[k] = ref_r[32*k +: 32];
            do_row("n4_rand", 4, ra, 1'b1);
        end

        // Zero-length start
        start = 1'b1; num_words = '0; a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_quiet", {62'd0, busy, out_valid}, 64'd0);
        @(negedge clk);
        check("zero_done_pulse", {63'd0, done}, 64'd0);
        check("zero_busy_after", {63'd0, busy}, 64'd0);

        // Reset during the 2nd word of an N=5 row
        start = 1'b1; num_words = 7'd5; a = 32'h7;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; b = 32'h1; z = 32'h0; out_ready = 1'b1;
        @(negedge clk);
        b = 32'h2;
        check("abort_first_out", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h7});
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", {29'd0, in_ready, out_valid, out_last, busy, done, out_data},
              64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        tb_b[0] = 32'h1; tb_z[0] = 32'h1;
        tb_exp[0] = 32'h4; tb_exp[1] = 32'h0;
        do_row("after_abort", 1, 32'h3, 1'b0);

`ifdef MAC_ROW_CIN_EN
        // Initial carry from cin_init
        cin_init = 32'h5;
        tb_b[0] = 32'hFFFF_FFFF; tb_z[0] = '0;
        tb_exp[0] = 32'h4; tb_exp[1] = 32'h1;
        do_row("cin", 1, 32'h1, 1'b0);
        cin_init = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
